spi_master_burst: RTL and testbench
===================================

SPI_MASTER_BURST -- requirements
Module: spi_master_burst

Interface
REQ-001 Parameter N, default 1: number of slave-select lines.
REQ-002 Parameter C, default 32: maximum word length in bits, 2..32.
REQ-003 Parameter CLK_RATIO, default 100: CLK_IN cycles per SPI_CLK half-period, at least 1.
REQ-004 Parameter SS_SPACE, default 1: SS setup and hold time, in half-periods, at least 1.
REQ-005 CLK_IN  in  1: single clock; all logic is on its rising edge.
REQ-006 RST_N  in  1: asynchronous, active-low reset.
REQ-007 din  in  C: transmit word; only bits [len-1:0] are used.
REQ-008 len  in  6: word length in bits, sampled at trigger.
REQ-009 trigger  in  1: start request, one cycle or held.
REQ-010 target  in  N: one-hot slave select, active high internally.
REQ-011 hold  in  1: when 1, SS stays asserted after this word completes.
REQ-012 CPOL, CPHA, LSB_FIRST  in  1 each: SPI mode and bit order.
REQ-013 MISO  in  1: serial data from the slave.
REQ-014 MOSI  out  1: serial data to the slave.
REQ-015 SPI_CLK  out  1: serial clock.
REQ-016 SPI_SS  out  N: slave selects, active low.
REQ-017 dout  out  C: received word, right-justified.
REQ-018 valid  out  1: one-cycle pulse when dout is updated.
REQ-019 busy  out  1: high from the accepted trigger until word completion.

Function
REQ-020 States: IDLE, HELD, SETUP, SHIFT, TRAIL.
REQ-021 A trigger is accepted only in IDLE or HELD; a trigger in any other state is ignored.
REQ-022 At accept, latch din, len, target, hold, CPOL, CPHA and LSB_FIRST; busy rises on the following cycle.
REQ-023 Effective length: len=0 or len>C uses C; otherwise len is used.
REQ-024 From IDLE: SPI_SS is driven to ~target on the cycle after accept; then SETUP lasts SS_SPACE*CLK_RATIO cycles; then SHIFT.
REQ-025 From HELD: SS is already asserted and the latched target is retained; a new target value is ignored; SETUP lasts CLK_RATIO cycles; then SHIFT.
REQ-026 SHIFT: each SPI_CLK period is two half-periods of CLK_RATIO cycles each.
REQ-027 SHIFT: the first half-period is the leading edge, the second is the trailing edge.
REQ-028 SHIFT ends after exactly len periods.
REQ-029 SPI_CLK equals CPOL outside SHIFT; inside SHIFT it is CPOL during the first half-period and ~CPOL during the second.
REQ-030 CPHA=0: the first bit is on MOSI when SETUP is entered; MISO is sampled at the leading edge; MOSI advances at the trailing edge.
REQ-031 CPHA=1: MOSI advances at the leading edge; MISO is sampled at the trailing edge.
REQ-032 Bit order LSB_FIRST=0: bits go out din[len-1] first; received bits fill dout from bit len-1 down to bit 0.
REQ-033 Bit order LSB_FIRST=1: bits go out din[0] first; received bits fill dout from bit 0 up to bit len-1.
REQ-034 dout[C-1:len] are 0; dout updates only at completion and otherwise holds its last value.
REQ-035 Completion with latched hold=0: enter TRAIL for SS_SPACE*CLK_RATIO cycles with SS asserted; then deassert SS, pulse valid, drop busy, go to IDLE.
REQ-036 Completion with latched hold=1: pulse valid, drop busy, go to HELD with SS asserted; no TRAIL.
REQ-037 HELD persists indefinitely until a trigger arrives; SS stays released only after a word launched with hold=0.
REQ-038 MOSI is 0 in IDLE and HELD.
REQ-039 A trigger in the same cycle as valid is accepted only if the state is already IDLE/HELD on that cycle; otherwise it is ignored.

Reset
REQ-040 On RST_N low, immediately: state IDLE, SPI_SS all 1, SPI_CLK=CPOL input, MOSI=0, valid=0, busy=0, dout=0.
REQ-041 Reset mid-transfer aborts the transfer with no valid pulse.
REQ-042 After RST_N rises, the first trigger can be accepted on the first rising edge of CLK_IN.

Verification
REQ-043 Mode 0, len=8, din=0xA5, MSB first, MISO looped to MOSI, CLK_RATIO=2 -> MOSI 1,0,1,0,0,1,0,1; dout=0x000000A5; one valid pulse; SS high afterwards.
REQ-044 Mode 3, LSB_FIRST=1, len=12, din=0x123, MISO held 1 -> first MOSI bit 1; SPI_CLK idles 1; dout=0x00000FFF.
REQ-045 Two words with hold=1 then hold=0, target=01 -> SS[0] stays low between words; the HELD setup is CLK_RATIO cycles; two valid pulses; SS rises after TRAIL.
REQ-046 trigger pulsed every cycle during SHIFT -> exactly one transfer; din changes during SHIFT are not transmitted.
REQ-047 RST_N low mid-word -> SS all 1 and SPI_CLK=CPOL in the same cycle; no valid pulse; a new trigger works normally.
REQ-048 len=0 and len=40 with C=32 -> both transfer exactly 32 bits.

Source files
------------

// File: rtl/spi_master_burst_if.sv
// Bundles the word-level request/response signals and the SPI pins of spi_master_burst.
// Request handshake: trigger is a request qualified by the master being IDLE or HELD; it is taken on that edge, busy is high from the next cycle until the word completes, and valid pulses once when dout carries the finished word.
interface spi_master_burst_if #(
  parameter int N = 1,
  parameter int C = 32
);
  logic [C-1:0] din;
  logic [5:0]   len;
  logic         trigger;
  logic [N-1:0] target;
  logic         hold;
  logic         CPOL;
  logic         CPHA;
  logic         LSB_FIRST;
  logic         MISO;
  logic         MOSI;
  logic         SPI_CLK;
  logic [N-1:0] SPI_SS;
  logic [C-1:0] dout;
  logic         valid;
  logic         busy;

  modport master (
    input  din, len, trigger, target, hold, CPOL, CPHA, LSB_FIRST, MISO,
    output MOSI, SPI_CLK, SPI_SS, dout, valid, busy
  );

  modport slave (
    output din, len, trigger, target, hold, CPOL, CPHA, LSB_FIRST, MISO,
    input  MOSI, SPI_CLK, SPI_SS, dout, valid, busy
  );
endinterface

// File: rtl/spi_master_burst.sv
// SPI master moving one word of up to C bits per trigger, with optional
// slave-select hold between words (burst) and selectable mode and bit order.
module spi_master_burst #(
  parameter int N         = 1,
  parameter int C         = 32,
  parameter int CLK_RATIO = 100,
  parameter int SS_SPACE  = 1
) (
  input  logic                  CLK_IN,
  input  logic                  RST_N,
  spi_master_burst_if.master    bus,
  output logic [2:0]            fsm_state
);

  typedef enum logic [2:0] {IDLE, HELD, SETUP, SHIFT, TRAIL} state_t;

  localparam int LONG = SS_SPACE * CLK_RATIO;
  localparam int CW   = (LONG > 1) ? $clog2(LONG + 1) : 1;
  localparam logic [CW-1:0] RATIO_LAST = CW'(CLK_RATIO - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [5:0]    bit_q, bit_d;

  logic [5:0]    len_q;
  logic          hold_q, cpol_q, cpha_q, lsb_q, from_held_q;
  logic [C-1:0]  tx_sr, rx_sr, rx_next, rx_just, dout_q;
  logic [N-1:0]  ss_q;
  logic          mosi_q, valid_q, busy_q;

  logic          accept, first_end, second_end, word_end, trail_end;
  logic          advance, sample, finish;
  logic [5:0]    eff_len;
  logic [C-1:0]  tx_mask, tx_masked, tx_aligned;

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    bit_d      = bit_q;
    accept     = 1'b0;
    first_end  = 1'b0;
    second_end = 1'b0;
    word_end   = 1'b0;
    trail_end  = 1'b0;
    case (state_q)
      IDLE, HELD: begin
        if (bus.trigger) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == (from_held_q ? RATIO_LAST : LONG_LAST)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_q == RATIO_LAST) begin
          cnt_d = '0;
          if (!half_q) begin
            first_end = 1'b1;
            half_d    = 1'b1;
          end else begin
            second_end = 1'b1;
            half_d     = 1'b0;
            bit_d      = bit_q + 6'd1;
            if (bit_q == len_q - 6'd1) begin
              word_end = 1'b1;
              state_d  = hold_q ? HELD : TRAIL;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TRAIL: begin
        if (cnt_q == LONG_LAST) begin
          trail_end = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Both modes move data on the half-period boundaries: CPHA=0 samples where
  // SPI_CLK leaves CPOL and shifts where it returns, CPHA=1 the other way round.
  assign advance = cpha_q ? first_end : second_end;
  assign sample  = cpha_q ? second_end : first_end;
  assign finish  = (word_end && hold_q) || trail_end;

  always_comb begin
    eff_len    = (bus.len == 6'd0 || int'(bus.len) > C) ? 6'(C) : bus.len;
    tx_mask    = {C{1'b1}} >> (C - int'(eff_len));
    tx_masked  = bus.din & tx_mask;
    tx_aligned = bus.LSB_FIRST ? tx_masked : (tx_masked << (C - int'(eff_len)));
    rx_next    = rx_sr;
    if (sample)
      rx_next = lsb_q ? {bus.MISO, rx_sr[C-1:1]} : {rx_sr[C-2:0], bus.MISO};
    rx_just = lsb_q ? (rx_next >> (C - int'(len_q))) : rx_next;
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      len_q       <= '0;
      hold_q      <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      from_held_q <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      dout_q      <= '0;
      ss_q        <= '1;
      mosi_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        len_q       <= eff_len;
        hold_q      <= bus.hold;
        cpol_q      <= bus.CPOL;
        cpha_q      <= bus.CPHA;
        lsb_q       <= bus.LSB_FIRST;
        from_held_q <= (state_q == HELD);
        busy_q      <= 1'b1;
        rx_sr       <= '0;
        if (state_q == IDLE)
          ss_q <= ~bus.target;
        if (bus.CPHA) begin
          mosi_q <= 1'b0;
          tx_sr  <= tx_aligned;
        end else begin
          mosi_q <= bus.LSB_FIRST ? tx_aligned[0] : tx_aligned[C-1];
          tx_sr  <= bus.LSB_FIRST ? (tx_aligned >> 1) : (tx_aligned << 1);
        end
      end else begin
        if (advance) begin
          mosi_q <= lsb_q ? tx_sr[0] : tx_sr[C-1];
          tx_sr  <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
        end
        rx_sr <= rx_next;
        if (finish) begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          dout_q  <= rx_just;
          mosi_q  <= 1'b0;
        end
        if (trail_end)
          ss_q <= '1;
      end
    end
  end

  // In IDLE the clock follows the live CPOL input so reset shows it at once.
  assign bus.SPI_CLK = (state_q == SHIFT) ? (cpol_q ^ half_q) :
                       (state_q == IDLE)  ? bus.CPOL : cpol_q;
  assign bus.MOSI    = (state_q == IDLE || state_q == HELD) ? 1'b0 : mosi_q;
  assign bus.SPI_SS  = ss_q;
  assign bus.dout    = dout_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed and randomized words against a bit-list model of the SPI master,
// with the bench acting as the slave on MISO.
module tb_spi_master_burst;
  localparam int N   = 2;
  localparam int C   = 32;
  localparam int R   = 2;
  localparam int SSP = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] fsm_state;
  logic       loop_en = 1'b0;
  logic       miso_drv = 1'b0;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic         held = 1'b0;
  logic [N-1:0] held_ss = '1;
  logic         last_pol = 1'b0;

  spi_master_burst_if #(.N(N), .C(C)) bus ();

  spi_master_burst #(.N(N), .C(C), .CLK_RATIO(R), .SS_SPACE(SSP)) dut (
    .CLK_IN   (clk),
    .RST_N    (rst_n),
    .bus      (bus),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  assign bus.MISO = loop_en ? bus.MOSI : miso_drv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // k-th bit on the wire, stored at index k
  function automatic logic [C-1:0] exp_tx(input logic [C-1:0] d, input int eff, input logic lsbf);
    logic [C-1:0] v;
    v = '0;
    for (int k = 0; k < eff; k++) v[k] = lsbf ? d[k] : d[eff-1-k];
    return v;
  endfunction

  // r[k] is the k-th bit the slave sent
  function automatic logic [C-1:0] exp_rx(input logic [C-1:0] r, input int eff, input logic lsbf);
    logic [C-1:0] v;
    v = '0;
    for (int k = 0; k < eff; k++) begin
      if (lsbf) v[k] = r[k];
      else      v[eff-1-k] = r[k];
    end
    return v;
  endfunction

  task automatic run_word(input string name, input logic [C-1:0] d, input logic [5:0] l,
                          input logic pol, input logic pha, input logic lsbf, input logic hld,
                          input logic [N-1:0] tgt, input logic loop, input logic [C-1:0] mw,
                          input logic spam);
    int eff, s_len, t_len, nb, first_cyc, vcnt, vcyc;
    logic [N-1:0] exp_ss, ss_v;
    logic [C-1:0] r, tx, got, dout_v;
    logic prev, busy_prev, busy_v, busy_last;
    eff    = (l == 0 || int'(l) > C) ? C : int'(l);
    s_len  = held ? R : SSP * R;
    t_len  = hld ? 0 : SSP * R;
    exp_ss = held ? held_ss : ~tgt;
    tx     = exp_tx(d, eff, lsbf);
    r      = loop ? tx : mw;
    loop_en = loop;
    nb = 0; first_cyc = -1; vcnt = 0; vcyc = -1;
    got = '0; dout_v = '0; ss_v = '0; busy_v = 1'b0; busy_prev = 1'b0; busy_last = 1'b0;
    prev = pol;
    bus.din = d; bus.len = l; bus.CPOL = pol; bus.CPHA = pha; bus.LSB_FIRST = lsbf;
    bus.hold = hld; bus.target = tgt; bus.trigger = 1'b1;
    miso_drv = r[0];
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        check({name, " busy_after_accept"}, 64'(bus.busy), 64'(1'b1));
        check({name, " ss_after_accept"}, 64'(bus.SPI_SS), 64'(exp_ss));
        if (!spam) bus.trigger = 1'b0;
      end
      if (bus.SPI_CLK !== prev) begin
        prev = bus.SPI_CLK;
        if (bus.SPI_CLK === ~pol) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (nb < C) begin
            got[nb] = bus.MOSI;
            if (pha) miso_drv = r[nb];
          end
          nb++;
        end else if (!pha && nb < C) begin
          miso_drv = r[nb];
        end
      end
      if (spam) begin
        if (nb < eff) begin
          bus.trigger = 1'b1;
          bus.din = $urandom;
        end else begin
          bus.trigger = 1'b0;
        end
      end
      if (bus.valid === 1'b1) begin
        vcnt++;
        if (vcyc < 0) begin
          vcyc = cyc; dout_v = bus.dout; ss_v = bus.SPI_SS;
          busy_v = bus.busy; busy_prev = busy_last;
        end
      end
      busy_last = bus.busy;
      if (vcyc >= 0 && cyc >= vcyc + 4) break;
    end
    bus.trigger = 1'b0;
    check({name, " first_clk_edge_cycle"}, 64'(first_cyc), 64'(s_len + R + 1));
    check({name, " clock_periods"}, 64'(nb), 64'(eff));
    check({name, " mosi_bits"}, 64'(got), 64'(tx));
    check({name, " valid_pulses"}, 64'(vcnt), 64'(1));
    check({name, " valid_cycle"}, 64'(vcyc), 64'(s_len + 2 * R * eff + t_len + 1));
    check({name, " dout"}, 64'(dout_v), 64'(exp_rx(r, eff, lsbf)));
    check({name, " ss_at_valid"}, 64'(ss_v), 64'(hld ? exp_ss : {N{1'b1}}));
    check({name, " busy_around_valid"}, 64'({busy_prev, busy_v}), 64'(2'b10));
    check({name, " idle_mosi"}, 64'(bus.MOSI), 64'(1'b0));
    check({name, " idle_clk"}, 64'(bus.SPI_CLK), 64'(pol));
    check({name, " idle_busy"}, 64'(bus.busy), 64'(1'b0));
    held = hld;
    held_ss = exp_ss;
    last_pol = pol;
  endtask

  initial begin
    logic pol, pha, lsbf, hld;
    logic [5:0] l;
    logic [N-1:0] tgt;
    int vseen;
    bus.din = '0; bus.len = '0; bus.trigger = 1'b0; bus.target = '0; bus.hold = 1'b0;
    bus.CPOL = 1'b1; bus.CPHA = 1'b0; bus.LSB_FIRST = 1'b0;

    // reset asserted before the first clock edge
    #2 rst_n = 1'b0;
    #1;
    check("reset ss", 64'(bus.SPI_SS), 64'({N{1'b1}}));
    check("reset clk", 64'(bus.SPI_CLK), 64'(1'b1));
    check("reset mosi", 64'(bus.MOSI), 64'(1'b0));
    check("reset valid", 64'(bus.valid), 64'(1'b0));
    check("reset busy", 64'(bus.busy), 64'(1'b0));
    check("reset dout", 64'(bus.dout), 64'(0));
    repeat (2) @(negedge clk);
    bus.CPOL = 1'b0;
    rst_n = 1'b1;

    run_word("mode0_a5", 32'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, '0, 1'b0);
    run_word("mode3_lsb", 32'h123, 6'd12, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, '1, 1'b0);
    run_word("burst_w1", 32'h3C5A, 6'd16, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_9E37, 1'b0);
    run_word("burst_w2", 32'h0F1, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0155, 1'b0);
    run_word("spam", 32'hC3, 6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, '0, 1'b1);
    run_word("len0", $urandom, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, $urandom, 1'b0);
    run_word("len40", $urandom, 6'd40, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, $urandom, 1'b0);

    for (int i = 0; i < 6; i++) begin
      pol  = held ? last_pol : 1'($urandom_range(0, 1));
      pha  = 1'($urandom_range(0, 1));
      lsbf = 1'($urandom_range(0, 1));
      hld  = (i == 5) ? 1'b0 : 1'($urandom_range(0, 1));
      l    = 6'($urandom_range(1, C));
      tgt  = N'(1) << $urandom_range(0, N - 1);
      run_word("random", $urandom, l, pol, pha, lsbf, hld, tgt, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // abort mid-word; no valid must follow
    bus.din = 32'hFFFF_0000; bus.len = 6'd20; bus.CPOL = 1'b1; bus.CPHA = 1'b1;
    bus.LSB_FIRST = 1'b0; bus.hold = 1'b0; bus.target = 2'b01; bus.trigger = 1'b1;
    @(negedge clk);
    bus.trigger = 1'b0;
    repeat (12) @(negedge clk);
    check("midword ss_low", 64'(bus.SPI_SS), 64'(2'b10));
    vseen = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort ss", 64'(bus.SPI_SS), 64'({N{1'b1}}));
    check("abort clk", 64'(bus.SPI_CLK), 64'(1'b1));
    check("abort busy", 64'(bus.busy), 64'(1'b0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) vseen++;
    end
    check("abort no_valid", 64'(vseen), 64'(0));
    held = 1'b0;
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    run_word("after_reset", $urandom, 6'd10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, $urandom, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
